// File: rtl/page_out_arbiter.sv
// page_out_arbiter
// Merges NUM_REQ operator output streams onto the single user-to-interface
// output port of a leaf_interface. Each grant covers at most BURST_LEN words.
// A grant is released early as soon as its owner drops valid. Arbitration is
// round-robin by default.
// Defining PAGE_ARB_FIXED_PRIO_EN switches the IDLE selection to fixed
// priority, where the lowest index wins.
// A 2-entry skid buffer decouples out_tready from the requester ready path.
module page_out_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    localparam int REQ_BITS  = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]            req_tvalid,
    output logic [NUM_REQ-1:0]            req_tready,
    output logic [DATA_WIDTH-1:0]         out_tdata,
    output logic                          out_tvalid,
    input  logic                          out_tready,
    output logic [REQ_BITS-1:0]           grant_id,
    output logic                          busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]            state;
    logic [REQ_BITS-1:0]   last_grant;
    logic [7:0]            burst_cnt;

    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            buf_cnt;

    logic [REQ_BITS-1:0]   sel_id;
    logic [REQ_BITS-1:0]   cand;
    logic                  any_valid;
    logic                  own_valid;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  buf_full;
    logic                  xfer;
    logic                  pop;
    logic                  burst_done;

    assign any_valid  = |req_tvalid;
    assign own_valid  = req_tvalid[grant_id];
    assign own_data   = req_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
    assign buf_full   = (buf_cnt == 2'd2);
    assign busy       = (state == ST_GRANT);
    assign xfer       = busy && own_valid && !buf_full;
    assign out_tvalid = (buf_cnt != 2'd0);
    assign pop        = out_tvalid && out_tready;
    assign burst_done = (burst_cnt == 8'(BURST_LEN - 1));
    // Empty-buffer head is forced to zero so stale words never leak out
    assign out_tdata  = out_tvalid ? buf_mem[rd_ptr] : '0;

    // Ready is decoded purely from registered state: owner only, and only with buffer room
    always_comb begin
        req_tready = '0;
        if (busy && !buf_full)
            req_tready[grant_id] = 1'b1;
    end

    // Next owner when leaving IDLE; the lowest-ranked candidate is written last and wins
    always_comb begin
        sel_id = '0;
        cand   = '0;
`ifdef PAGE_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = REQ_BITS'(i);
            if (req_tvalid[cand])
                sel_id = cand;
        end
`else
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = REQ_BITS'((int'(last_grant) + k) % NUM_REQ);
            if (req_tvalid[cand])
                sel_id = cand;
        end
`endif
    end

    // Grant FSM: burst counting and release on burst end or owner valid drop
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= REQ_BITS'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_id  <= sel_id;
                        burst_cnt <= '0;
                        state     <= ST_GRANT;
                    end
                end
                default: begin
                    if (xfer)
                        burst_cnt <= burst_cnt + 8'd1;
                    if ((xfer && burst_done) || !own_valid) begin
                        state      <= ST_IDLE;
                        last_grant <= grant_id;
                    end
                end
            endcase
        end
    end

    // Skid buffer occupancy and pointers; push and pop together keep the count
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (xfer)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({xfer, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Skid buffer storage; contents are qualified by buf_cnt so they need no reset
    always_ff @(posedge ap_clk) begin
        if (xfer)
            buf_mem[wr_ptr] <= own_data;
    end

endmodule

// File: doc/page_out_arbiter.md
# page_out_arbiter

Merges up to NUM_REQ operator output streams onto the single user-to-interface output port of a page's leaf_interface, so several HLS operators in one page can share one output port toward the BFT. Grants are burst-based and round-robin by default, and a burst is released early when the owner stops streaming. A 2-entry skid buffer on the output side isolates `out_tready` from the requester `tready` paths. It sits between the operator `Output_*_V_T*` stream ports and the leaf_interface `din_leaf_user2interface` / `vld_user2interface` / `ack_interface2user` signals.

## Interface
- NUM_REQ, 4, number of requester streams (2..8)
- DATA_WIDTH, 32, stream word width (matches leaf_interface PAYLOAD_BITS)
- BURST_LEN, 16, maximum words per grant (1..255)
- Derived localparam REQ_BITS = max(1, clog2(NUM_REQ))
- ap_clk  in  1  clock, all logic rising-edge
- ap_rst_n  in  1  asynchronous, active-low reset
- req_tdata  in  NUM_REQ*DATA_WIDTH  requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_tvalid  in  NUM_REQ  per-requester valid
- req_tready  out  NUM_REQ  per-requester ready; at most one bit high
- out_tdata  out  DATA_WIDTH  to leaf_interface din_leaf_user2interface
- out_tvalid  out  1  to vld_user2interface
- out_tready  in  1  from ack_interface2user
- grant_id  out  REQ_BITS  current or last granted requester index
- busy  out  1  high in GRANT state

## Operation
- States: IDLE, GRANT. Registers: `state`, `grant_id`, `last_grant`, `burst_cnt` (8 bits), 2-entry buffer with `buf_cnt` (0..2).
- IDLE:
  - If any `req_tvalid` is high, select the first requester with valid high, scanning circularly from `last_grant+1`.
  - Register the selection into `grant_id`, clear `burst_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `req_tready[grant_id] = (buf_cnt != 2)`; all other `req_tready` bits are 0.
  - Transfer occurs when `req_tvalid[grant_id] & req_tready[grant_id]`; the word is pushed to the buffer and `burst_cnt` increments.
  - Release (go to IDLE, set `last_grant = grant_id`) when either:
    - a transfer brings `burst_cnt` to BURST_LEN, or
    - `req_tvalid[grant_id]` is low in any GRANT cycle, regardless of buffer state.
  - Release on the BURST_LEN condition takes precedence; both conditions release identically.
- Buffer:
  - FIFO order. `out_tvalid = (buf_cnt != 0)`; `out_tdata` is the head entry.
  - Pop on `out_tvalid & out_tready`.
  - Simultaneous push and pop leaves `buf_cnt` unchanged and preserves order.
  - Push is never attempted when `buf_cnt == 2`.
- Word order within a requester is preserved. No word is dropped or duplicated under any backpressure pattern.
- A requester with valid low is never granted. A newly asserted valid from another requester does not preempt an active grant.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, grant_id = 0, last_grant = NUM_REQ-1 (first grant favours requester 0), burst_cnt = 0, buf_cnt = 0.
  - Outputs: out_tvalid = 0, out_tdata = 0, req_tready = 0, busy = 0.
- `req_tready` and `busy` are decoded from registers only. There is no combinational path from `out_tready` or `req_tvalid` to `req_tready`.
- Arbitration latency:
  - `req_tvalid` seen in IDLE at cycle t → GRANT at t+1, with the first transfer possible at t+1.
  - That word appears on `out_tdata` at t+2 if the buffer was empty.
- Throughput:
  - One word per cycle within a burst while `out_tready` is held high (`buf_cnt` stays at 1).
  - Each re-arbitration costs exactly one IDLE bubble cycle on the requester side.
- Reset asserted mid-burst: the buffer contents are discarded and every output returns to its reset value immediately.

## Configuration
- `PAGE_ARB_FIXED_PRIO_EN` defined:
  - IDLE selection is fixed priority: lowest index with valid high wins.
  - `last_grant` is not used for selection.
  - Burst length and early release are unchanged.
- Undefined (default): round-robin selection as above.

## Test plan
- Reset only requester 0 streaming 40 words (0x1000..0x1027), `out_tready = 1`:
  - Bursts of 16, 16, 8, with one `req_tready`-low bubble between bursts.
  - `out_tdata` carries 0x1000..0x1027 in order.
- All 4 requesters valid continuously, `out_tready = 1`:
  - `grant_id` sequence is 0,1,2,3,0, with 16 words each.
  - Every burst is contiguous and from a single source.
- Requester 1 drops valid after 3 words with requester 2 pending:
  - Release in the drop cycle, IDLE for 1 cycle, then grant to 2.
  - The next grant to 1 happens only after 2 and 3 have been offered.
- `out_tready` held low 5 cycles mid-burst:
  - `buf_cnt` reaches 2 and `req_tready` goes low.
  - After `out_tready` returns high, all words are delivered in order with no loss.
- `ap_rst_n` pulsed low mid-burst with `buf_cnt = 2`:
  - `out_tvalid`, `req_tready` and `busy` drop to 0 asynchronously.
  - After release, the first grant goes to requester 0.
- With `PAGE_ARB_FIXED_PRIO_EN` defined, requesters 0 and 2 continuously valid:
  - Only requester 0 is ever granted, in 16-word bursts separated by 1-cycle bubbles.
